// File: rtl/sap3_pkg.sv
// Shared types and constants for the SAP-3 CPU-to-SRAM bridge.
// Used by sap3_mem_bridge and, when SAP3_BRIDGE_TRACE_EN is defined, sap3_trace_ser.
package sap3_pkg;

  localparam int MAR_W   = 16;
  localparam int SRAM_AW = 10;
  localparam int BYTE_AW = 12;

  // Any address bit above the 4 KiB window marks the access out-of-range.
  localparam logic [MAR_W-1:0] OOR_MASK = 16'hF000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic logic is_oor(input logic [MAR_W-1:0] addr);
    return (addr & OOR_MASK) != '0;
  endfunction

endpackage

// File: rtl/sap3_trace_ser.sv
// LSB-first byte serialiser for the write trace; only built when SAP3_BRIDGE_TRACE_EN is defined.
// A start request while a byte is still shifting out is ignored.
module sap3_trace_ser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       trace_ser,
  output logic       trace_start
);

  logic [7:0] shreg;
  logic [3:0] count;
  logic       first;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
      first <= 1'b0;
    end else if (count == 4'd0) begin
      if (start) begin
        shreg <= data;
        count <= 4'd8;
        first <= 1'b1;
      end
    end else begin
      shreg <= {1'b0, shreg[7:1]};
      count <= count - 4'd1;
      first <= 1'b0;
    end
  end

  assign trace_ser   = (count != 4'd0) & shreg[0];
  assign trace_start = first;

endmodule

// File: rtl/sap3_mem_bridge.sv
// Bridges the SAP-3 CPU MAR/RAM strobes onto a 1024x32 byte-masked SRAM macro.
// Define SAP3_BRIDGE_TRACE_EN to add the serial write-trace output.
module sap3_mem_bridge
  import sap3_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_mar_we,
  input  logic               cpu_ram_we,
  input  logic [7:0]         cpu_addr_hi,
  input  logic [7:0]         cpu_bus,
  output logic [7:0]         cpu_rdata,
  output logic               rdata_valid,
  output logic               oor_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_bm,
  output logic [31:0]        sram_din,
  output logic               sram_men,
  output logic               sram_wen,
  output logic               sram_ren,
  input  logic [31:0]        sram_dout,
  output logic               trace_ser,
  output logic               trace_start
);

  state_t             state, next_state;
  logic [MAR_W-1:0]   mar;
  logic [MAR_W-1:0]   wr_addr;
  logic [7:0]         wr_data;
  logic [1:0]         rd_lane;
  logic               rd_oor;
  logic               first_valid;
  logic [7:0]         rdata_q;
  logic [7:0]         fetch_byte;

  assign fetch_byte = rd_oor ? 8'h00 : sram_dout[{rd_lane, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mar         <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_lane     <= '0;
      rd_oor      <= 1'b0;
      first_valid <= 1'b0;
      rdata_q     <= '0;
      oor_err     <= 1'b0;
    end else begin
      state <= next_state;
      if (cpu_mar_we)
        mar <= {cpu_addr_hi, cpu_bus};
      // The write keeps the MAR as it was before any same-cycle reload.
      if (cpu_ram_we) begin
        wr_addr <= mar;
        wr_data <= cpu_bus;
      end
      if (state == FETCH) begin
        rd_lane <= mar[1:0];
        rd_oor  <= is_oor(mar);
      end
      first_valid <= (state == FETCH) && (next_state == VALID);
      if (first_valid)
        rdata_q <= fetch_byte;
      if ((state == FETCH && is_oor(mar)) || (state == WRITE && is_oor(wr_addr)))
        oor_err <= 1'b1;
    end
  end

  // SRAM read data lands during the first VALID cycle, so it is forwarded there and held afterwards.
  assign cpu_rdata   = first_valid ? fetch_byte : rdata_q;
  assign rdata_valid = (state == VALID);

  // Enables are qualified by rst_n so a reset asserted mid-WRITE never reaches the macro.
  always_comb begin
    next_state = state;
    sram_addr  = mar[BYTE_AW-1:2];
    sram_bm    = '0;
    sram_din   = '0;
    sram_men   = 1'b0;
    sram_wen   = 1'b0;
    sram_ren   = 1'b0;
    case (state)
      IDLE:  next_state = FETCH;
      FETCH: begin
        next_state = VALID;
        if (rst_n && !is_oor(mar)) begin
          sram_men = 1'b1;
          sram_ren = 1'b1;
        end
      end
      VALID: next_state = VALID;
      WRITE: begin
        next_state = FETCH;
        sram_addr  = wr_addr[BYTE_AW-1:2];
        if (rst_n && !is_oor(wr_addr)) begin
          sram_men = 1'b1;
          sram_wen = 1'b1;
          sram_bm  = 32'h0000_00FF << {wr_addr[1:0], 3'b000};
          sram_din = {4{wr_data}};
        end
      end
      default: next_state = IDLE;
    endcase
    if (cpu_ram_we)
      next_state = WRITE;
    else if (cpu_mar_we)
      next_state = FETCH;
  end

`ifdef SAP3_BRIDGE_TRACE_EN
  sap3_trace_ser u_trace (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       ((state == WRITE) && rst_n && !is_oor(wr_addr)),
    .data        (wr_data),
    .trace_ser   (trace_ser),
    .trace_start (trace_start)
  );
`else
  assign trace_ser   = 1'b0;
  assign trace_start = 1'b0;
`endif

endmodule

// File: tb/tb_sap3_mem_bridge.sv
// Directed testbench for sap3_mem_bridge with a behavioural 1024x32 SRAM (one-cycle read latency).
// Trace checks are compiled in only when SAP3_BRIDGE_TRACE_EN is defined.
module tb_sap3_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_mar_we;
  logic        cpu_ram_we;
  logic [7:0]  cpu_addr_hi;
  logic [7:0]  cpu_bus;
  logic [7:0]  cpu_rdata;
  logic        rdata_valid;
  logic        oor_err;
  logic [9:0]  sram_addr;
  logic [31:0] sram_bm;
  logic [31:0] sram_din;
  logic        sram_men;
  logic        sram_wen;
  logic        sram_ren;
  logic [31:0] sram_dout = '0;
  logic        trace_ser;
  logic        trace_start;

  logic [31:0] mem [1024] = '{default: 32'h0};
  int          wen_count = 0;
  int          checks = 0;
  int          errors = 0;
  int          w0;

  always #5 clk = ~clk;

  sap3_mem_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_mar_we  (cpu_mar_we),
    .cpu_ram_we  (cpu_ram_we),
    .cpu_addr_hi (cpu_addr_hi),
    .cpu_bus     (cpu_bus),
    .cpu_rdata   (cpu_rdata),
    .rdata_valid (rdata_valid),
    .oor_err     (oor_err),
    .sram_addr   (sram_addr),
    .sram_bm     (sram_bm),
    .sram_din    (sram_din),
    .sram_men    (sram_men),
    .sram_wen    (sram_wen),
    .sram_ren    (sram_ren),
    .sram_dout   (sram_dout),
    .trace_ser   (trace_ser),
    .trace_start (trace_start)
  );

  // Behavioural SRAM macro: byte-masked write, registered read data.
  always @(posedge clk) begin
    if (sram_men && sram_wen) begin
      mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
      wen_count <= wen_count + 1;
    end
    if (sram_men && sram_ren)
      sram_dout <= mem[sram_addr];
  end

  // Drive one cycle of CPU strobes, then land 1 time unit after the edge.
  task automatic applyStimulus(input logic mar_we, input logic ram_we,
                               input logic [7:0] hi, input logic [7:0] bus);
    cpu_mar_we  = mar_we;
    cpu_ram_we  = ram_we;
    cpu_addr_hi = hi;
    cpu_bus     = bus;
    @(posedge clk);
    #1;
    cpu_mar_we = 1'b0;
    cpu_ram_we = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic loadMar(input logic [15:0] addr);
    applyStimulus(1'b1, 1'b0, addr[15:8], addr[7:0]);
  endtask

  task automatic writeByte(input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, 8'h00, data);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] trace_byte;
    rst_n = 1'b0;
    idle();
    idle();
    $display("[TB] reset state");
    checkOutput("rst_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("rst_rdata", {24'd0, cpu_rdata}, 32'h00);
    checkOutput("rst_oor", {31'd0, oor_err}, 32'd0);
    checkOutput("rst_men", {31'd0, sram_men}, 32'd0);
    checkOutput("rst_bm", sram_bm, 32'h0);
    checkOutput("rst_trace", {30'd0, trace_ser, trace_start}, 32'd0);
    rst_n = 1'b1;
    idle();
    idle();

    $display("[TB] write 0xA5 at 0x0005, read back");
    loadMar(16'h0005);
    checkOutput("ld_valid_low", {31'd0, rdata_valid}, 32'd0);
    writeByte(8'hA5);
    checkOutput("wr1_wen", {30'd0, sram_men, sram_wen}, 32'd3);
    checkOutput("wr1_ren", {31'd0, sram_ren}, 32'd0);
    checkOutput("wr1_addr", {22'd0, sram_addr}, 32'd1);
    checkOutput("wr1_bm", sram_bm, 32'h0000FF00);
    checkOutput("wr1_din", sram_din, 32'hA5A5A5A5);
    checkOutput("wr1_valid", {31'd0, rdata_valid}, 32'd0);
    idle();
    loadMar(16'h0005);
    checkOutput("rd1_valid_c1", {31'd0, rdata_valid}, 32'd0);
    idle();
    checkOutput("rd1_valid_c2", {31'd0, rdata_valid}, 32'd1);
    checkOutput("rd1_rdata", {24'd0, cpu_rdata}, 32'hA5);
    checkOutput("valid_bm", sram_bm, 32'h0);
    idle();
    checkOutput("rd1_hold", {24'd0, cpu_rdata}, 32'hA5);

    $display("[TB] four byte lanes at 0x0010");
    loadMar(16'h0010);
    writeByte(8'h11);
    loadMar(16'h0011);
    writeByte(8'h22);
    loadMar(16'h0012);
    writeByte(8'h33);
    loadMar(16'h0013);
    writeByte(8'h44);
    checkOutput("wr4_bm", sram_bm, 32'hFF000000);
    idle();
    checkOutput("word4", mem[4], 32'h44332211);
    loadMar(16'h0012);
    idle();
    checkOutput("rd12_valid", {31'd0, rdata_valid}, 32'd1);
    checkOutput("rd12_rdata", {24'd0, cpu_rdata}, 32'h33);

    $display("[TB] out-of-range 0x1000");
    loadMar(16'h1000);
    checkOutput("oor_fetch_men", {31'd0, sram_men}, 32'd0);
    w0 = wen_count;
    writeByte(8'hFF);
    checkOutput("oor_wr_en", {29'd0, sram_men, sram_wen, sram_ren}, 32'd0);
    checkOutput("oor_wr_bm", sram_bm, 32'h0);
    idle();
    checkOutput("oor_no_wen", w0, wen_count);
    checkOutput("oor_err", {31'd0, oor_err}, 32'd1);
    checkOutput("oor_word0", mem[0], 32'h0);
    idle();
    checkOutput("oor_rd_valid", {31'd0, rdata_valid}, 32'd1);
    checkOutput("oor_rd_rdata", {24'd0, cpu_rdata}, 32'h00);

    $display("[TB] simultaneous MAR load and RAM write");
    loadMar(16'h0020);
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h30);
    checkOutput("sim_wr_addr", {22'd0, sram_addr}, 32'h008);
    checkOutput("sim_wr_bm", sram_bm, 32'h000000FF);
    checkOutput("sim_wr_din", sram_din, 32'h30303030);
    idle();
    checkOutput("sim_fetch_addr", {22'd0, sram_addr}, 32'h00C);
    checkOutput("sim_fetch_ren", {31'd0, sram_ren}, 32'd1);
    checkOutput("sim_word8", mem[8], 32'h00000030);
    idle();
    checkOutput("sim_rd_rdata", {24'd0, cpu_rdata}, 32'h00);

    $display("[TB] reset during WRITE");
    loadMar(16'h0040);
    writeByte(8'h77);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_wen", {30'd0, sram_men, sram_wen}, 32'd0);
    w0 = wen_count;
    idle();
    checkOutput("rstw_no_wen", w0, wen_count);
    checkOutput("rstw_word16", mem[16], 32'h0);
    checkOutput("rstw_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("rstw_rdata", {24'd0, cpu_rdata}, 32'h00);
    checkOutput("rstw_oor", {31'd0, oor_err}, 32'd0);
    checkOutput("rstw_en", {29'd0, sram_men, sram_wen, sram_ren}, 32'd0);
    checkOutput("rstw_trace", {30'd0, trace_ser, trace_start}, 32'd0);
    rst_n = 1'b1;
    idle();
    idle();

`ifdef SAP3_BRIDGE_TRACE_EN
    $display("[TB] write trace of 0x96");
    loadMar(16'h0050);
    writeByte(8'h96);
    idle();
    trace_byte = 8'h96;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("trace_bit%0d", i), {31'd0, trace_ser}, {31'd0, trace_byte[i]});
      checkOutput($sformatf("trace_start%0d", i), {31'd0, trace_start}, (i == 0) ? 32'd1 : 32'd0);
      idle();
    end
    checkOutput("trace_done", {30'd0, trace_ser, trace_start}, 32'd0);
`else
    trace_byte = 8'h00;
    loadMar(16'h0050);
    writeByte(8'h96);
    idle();
    checkOutput("trace_tied", {30'd0, trace_ser, trace_start}, {30'd0, trace_byte[0], trace_byte[1]});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap3_mem_bridge.md
SAP3_MEM_BRIDGE -- requirements
Module: sap3_mem_bridge

Interface
REQ-001 SHALL provide: clk  in  1  clock, all logic on rising edge.
REQ-002 SHALL provide: rst_n  in  1  reset; synchronous, active-low.
REQ-003 SHALL provide: cpu_mar_we  in  1  CPU MAR load strobe.
REQ-004 SHALL provide: cpu_ram_we  in  1  CPU RAM write strobe.
REQ-005 SHALL provide: cpu_addr_hi  in  8  MAR high byte, driven on the CPU uio_oe pins.
REQ-006 SHALL provide: cpu_bus  in  8  MAR low byte and write data, driven on the CPU uio_out pins.
REQ-007 SHALL provide: cpu_rdata  out  8  read byte for the CPU ui_in pins.
REQ-008 SHALL provide: rdata_valid  out  1  cpu_rdata matches the current MAR.
REQ-009 SHALL provide: oor_err  out  1  sticky out-of-range access flag.
REQ-010 SHALL provide the SRAM port: sram_addr out 10, sram_bm out 32, sram_din out 32, sram_men out 1, sram_wen out 1, sram_ren out 1, sram_dout in 32 (one-cycle read latency).
REQ-011 SHALL provide: trace_ser  out  1  serial write-trace data, and trace_start  out  1  first-bit marker.

Function
REQ-012 MAR (16 bit) SHALL load {cpu_addr_hi, cpu_bus} on the edge where cpu_mar_we=1.
REQ-013 The byte address is mar[11:0]: word = mar[11:2] and lane = mar[1:0]. This packs 4 KiB into the 1024x32 macro.
REQ-014 An access with mar[15:12]!=0 is out-of-range (OOR).
REQ-015 The FSM SHALL have four states: IDLE, FETCH, VALID and WRITE. It SHALL enter IDLE on reset.
REQ-016 FSM transitions:
- IDLE goes to FETCH.
- FETCH goes to VALID.
- VALID holds.
- WRITE goes to FETCH.
- cpu_mar_we in any state forces FETCH next cycle, unless REQ-019 applies.
REQ-017 In FETCH with an in-range MAR, the block SHALL drive sram_men=1, sram_ren=1, sram_wen=0 and sram_addr=mar[11:2]. It SHALL also register the lane.
REQ-018 On entry to VALID, the block SHALL register cpu_rdata = sram_dout[8*lane+:8] and assert rdata_valid. An OOR FETCH SHALL issue no SRAM enable and SHALL yield cpu_rdata=0x00.
REQ-019 When cpu_ram_we=1, the block SHALL capture cpu_bus and the current (pre-update) MAR, then go to WRITE next cycle. This applies even if cpu_mar_we is also 1.
REQ-020 In WRITE, the block SHALL drive sram_men=1, sram_wen=1, sram_ren=0, sram_bm=0xFF<<(8*lane) and sram_din={4{data}}.
REQ-021 cpu_ram_we asserted during WRITE SHALL re-capture and stay in WRITE, giving back-to-back writes.
REQ-022 An OOR write SHALL drive no SRAM enables and SHALL set oor_err. An OOR read SHALL also set oor_err.
REQ-023 rdata_valid SHALL be 0 in IDLE, FETCH and WRITE, and in the cycle after any cpu_mar_we.
REQ-024 A read after a write to the same address SHALL return the new byte once in VALID.
REQ-025 Outside FETCH and WRITE, all SRAM enables SHALL be 0 and sram_bm SHALL be 0.

Reset
REQ-026 When rst_n=0 at an edge, the block SHALL set mar=0, state=IDLE, cpu_rdata=0x00, rdata_valid=0, oor_err=0, trace_ser=0 and trace_start=0.
REQ-027 A reset during WRITE SHALL abort the write, with no sram_wen pulse in the following cycle.

Configuration
REQ-028 Macro SAP3_BRIDGE_TRACE_EN, when defined:
- Each in-range write SHALL be serialised LSB-first over 8 cycles on trace_ser, starting the cycle after WRITE.
- trace_start SHALL be 1 during bit 0 only.
- A write arriving while the serialiser is busy SHALL be dropped from the trace only (the SRAM write still occurs).
REQ-029 When SAP3_BRIDGE_TRACE_EN is undefined, trace_ser and trace_start SHALL be tied to 0 and no serialiser logic SHALL be present.

Structure
REQ-030 Package sap3_pkg SHALL hold: the state enum, MAR_W=16, SRAM_AW=10, BYTE_AW=12, and the OOR mask.
REQ-031 The trace serialiser SHALL be the sub-module sap3_trace_ser, instantiated only under SAP3_BRIDGE_TRACE_EN.

Verification
REQ-032 Load MAR=0x0005, write 0xA5:
- Expected: sram_addr=1, sram_bm=0x0000FF00, sram_din=0xA5A5A5A5.
- Then reload MAR=0x0005: rdata_valid after 2 cycles, cpu_rdata=0xA5.
REQ-033 Write bytes 0x11, 0x22, 0x33, 0x44 to MAR 0x0010-0x0013.
- Expected: word 4 = 0x44332211.
- Reading 0x0012 returns 0x33.
REQ-034 MAR=0x1000 with a write of 0xFF:
- Expected: no sram_wen, and oor_err=1.
- A read returns 0x00.
REQ-035 Simultaneous cpu_ram_we and cpu_mar_we (old MAR=0x0020, new 0x0030):
- Expected: the write lands at 0x0020.
- The next FETCH uses word 0x00C.
REQ-036 Assert rst_n=0 in the WRITE cycle. Expected: no sram_wen, and all outputs at their reset values.
REQ-037 With SAP3_BRIDGE_TRACE_EN, write 0x96. Expected: trace_ser sequence 0,1,1,0,1,0,0,1, with trace_start on the first bit.
